// File: rtl/led_fader.sv
// Per-LED fade stage: a set PIO bit lights its LED solid; a cleared bit fades out via time-sliced PWM.
// Optional macro LED_FADER_GAMMA_EN maps level to duty through a 16-entry gamma ROM (linear when undefined).

module led_fader_lane (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_enable,
    input  logic       i_led,
    input  logic       i_decay,
    input  logic [3:0] i_pwm_cnt,
    output logic       o_led
);
    logic [3:0] r_lvl;
    logic [3:0] w_duty;
    logic       r_led;

`ifdef LED_FADER_GAMMA_EN
    always_comb begin
        w_duty = 4'd0;
        case (r_lvl)
            4'd3:    w_duty = 4'd1;
            4'd4:    w_duty = 4'd1;
            4'd5:    w_duty = 4'd2;
            4'd6:    w_duty = 4'd2;
            4'd7:    w_duty = 4'd3;
            4'd8:    w_duty = 4'd4;
            4'd9:    w_duty = 4'd5;
            4'd10:   w_duty = 4'd6;
            4'd11:   w_duty = 4'd8;
            4'd12:   w_duty = 4'd9;
            4'd13:   w_duty = 4'd11;
            4'd14:   w_duty = 4'd13;
            4'd15:   w_duty = 4'd15;
            default: w_duty = 4'd0;
        endcase
    end
`else
    assign w_duty = r_lvl;
`endif

    // A held-high input wins over a coincident decay step, so a re-trigger always restarts at full level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lvl <= 4'd0;
            r_led <= 1'b0;
        end else if (!i_enable) begin
            r_lvl <= 4'd0;
            r_led <= i_led;
        end else begin
            if (i_led)
                r_lvl <= 4'd15;
            else if (i_decay && (r_lvl != 4'd0))
                r_lvl <= r_lvl - 4'd1;
            r_led <= i_led | (w_duty > i_pwm_cnt);
        end
    end

    assign o_led = r_led;
endmodule

module led_fader #(
    parameter int NUM_LEDS  = 10,
    parameter int PRESCALE  = 50000,
    parameter int DECAY_DIV = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] out_led,
    output logic                frame_pulse
);
    localparam int PRE_W = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'(DECAY_DIV - 1);

    logic [PRE_W-1:0] r_pre_cnt;
    logic [3:0]       r_pwm_cnt;
    logic [DEC_W-1:0] r_dec_cnt;
    logic             r_frame_pulse;
    logic             w_tick;
    logic             w_frame_end;
    logic             w_decay;

    assign w_tick      = (r_pre_cnt == PRE_MAX);
    assign w_frame_end = w_tick && (r_pwm_cnt == 4'hF);
    assign w_decay     = w_frame_end && (r_dec_cnt == DEC_MAX);

    // Bypass parks every counter at 0 so that re-enabling starts a fresh frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt     <= '0;
            r_pwm_cnt     <= 4'd0;
            r_dec_cnt     <= '0;
            r_frame_pulse <= 1'b0;
        end else if (!enable) begin
            r_pre_cnt     <= '0;
            r_pwm_cnt     <= 4'd0;
            r_dec_cnt     <= '0;
            r_frame_pulse <= 1'b0;
        end else begin
            r_pre_cnt     <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (w_frame_end)
                r_dec_cnt <= w_decay ? '0 : r_dec_cnt + DEC_W'(1);
            r_frame_pulse <= w_frame_end;
        end
    end

    assign frame_pulse = r_frame_pulse;

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_lane
        led_fader_lane u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_enable  (enable),
            .i_led     (led_in[gi]),
            .i_decay   (w_decay),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (out_led[gi])
        );
    end
endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with PRESCALE=2, DECAY_DIV=2 (32-clk frame, 64-clk decay step).
// Build with LED_FADER_GAMMA_EN defined to check the gamma duty table instead of linear duty.

module tb_led_fader;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [9:0] led_in;
    logic [9:0] out_led;
    logic       frame_pulse;
    int         n_chk  = 0;
    int         n_pass = 0;

`ifdef LED_FADER_GAMMA_EN
    localparam int GAM [16] = '{0,0,0,1,1,2,2,3,4,5,6,8,9,11,13,15};
`endif

    always #5 clk = ~clk;

    led_fader #(.NUM_LEDS(10), .PRESCALE(2), .DECAY_DIV(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .led_in      (led_in),
        .out_led     (out_led),
        .frame_pulse (frame_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int duty(input int l);
`ifdef LED_FADER_GAMMA_EN
        return GAM[l];
`else
        return l;
`endif
    endfunction

    // One 32-clk frame: count high samples of bit 0, require bits 9:1 solid and a frame pulse at the end.
    task automatic run_frame(input string tag, input int raise_at, input int exp_hi);
        int         hi = 0;
        logic [8:0] a  = '1;
        for (int i = 1; i <= 32; i++) begin
            step();
            hi += int'(out_led[0]);
            a  &= out_led[9:1];
            if (i == raise_at) led_in = 10'h3FF;
        end
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " b9_1"}, {23'd0, a}, 32'h1FF);
        chk({tag, " fp"}, {31'd0, frame_pulse}, 32'd1);
    endtask

    // Counts clocks to the first frame pulse after counting starts; out must stay dark meanwhile.
    task automatic wait_fp(input string tag);
        int         n   = 0;
        logic [9:0] orv = '0;
        do begin
            step();
            n++;
            orv |= out_led;
        end while (!frame_pulse && n < 40);
        chk({tag, " len"}, n, 32);
        chk({tag, " dark"}, {22'd0, orv}, 32'd0);
    endtask

    initial begin
        logic       orfp;
        logic       same;
        reset_n = 1'b0;
        enable  = 1'b1;
        led_in  = 10'h000;
        repeat (3) step();
        chk("rst out", {22'd0, out_led}, 32'd0);
        chk("rst fp", {31'd0, frame_pulse}, 32'd0);

        reset_n = 1'b1;
        wait_fp("rel");

        led_in = 10'h3FF;
        run_frame("solid", 0, 32);

        led_in = 10'h3FE;
        for (int n = 3; n <= 36; n++) begin
            int l;
            l = 16 - (n - 1) / 2;
            if (l < 0) l = 0;
            run_frame($sformatf("fade%0d", n), 0, 2 * duty(l));
        end

        led_in = 10'h3FF;
        run_frame("rt_hold", 0, 32);
        led_in = 10'h3FE;
        run_frame("rt_f38", 0, 2 * duty(15));
        run_frame("rt_f39", 0, 2 * duty(14));
        run_frame("rt_f40", 31, 2 * duty(14) + 1);
        chk("rt_out", {31'd0, out_led[0]}, 32'd1);
        led_in = 10'h3FE;
        run_frame("rt_f41", 0, 2 * duty(15));

        enable = 1'b0;
        led_in = 10'h155;
        step();
        chk("byp out", {22'd0, out_led}, 32'h155);
        chk("byp fp0", {31'd0, frame_pulse}, 32'd0);
        orfp = 1'b0;
        same = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            orfp |= frame_pulse;
            if (out_led !== 10'h155) same = 1'b0;
        end
        chk("byp fp", {31'd0, orfp}, 32'd0);
        chk("byp hold", {31'd0, same}, 32'd1);

        enable = 1'b1;
        led_in = 10'h000;
        wait_fp("en_rise");

        led_in = 10'h3FF;
        run_frame("pre_rst", 0, 32);
        led_in = 10'h3FE;
        repeat (5) step();
        chk("mid fade out", {22'd0, out_led}, 32'h3FF);
        reset_n = 1'b0;
        #1;
        chk("async rst out", {22'd0, out_led}, 32'd0);
        chk("async rst fp", {31'd0, frame_pulse}, 32'd0);
        led_in = 10'h000;
        step();
        reset_n = 1'b1;
        wait_fp("rst_rel");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
